// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency RAM between instruction fetch (IF)
// and the MEM stage. Each access holds ram_en for LATENCY cycles, then the
// read data is registered and a one-cycle ready pulse goes back to the owner.
// When both sides are waiting, grants alternate so neither side is starved.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2      // RAM access cycles, 1..15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM
    } state_t;

    typedef enum logic {
        GRANT_IF,
        GRANT_MEM
    } side_t;

    // The access counter starts at LATENCY-1 and completes when it reaches zero
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state, state_n;
    side_t             last_grant, last_grant_n;
    logic [3:0]        cnt, cnt_n;
    logic              ram_en_n, ram_we_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [DATA_W-1:0] ram_wdata_n;
    logic [DATA_W-1:0] if_rdata_n, mem_rdata_n;
    logic              if_ready_n, mem_ready_n;

    logic              if_elig, mem_elig, grant_mem;

    // A side whose ready is pulsing this cycle has just been served, so its
    // still-high request is not a new one; on a tie the side not served last wins
    assign if_elig   = if_req & ~if_ready;
    assign mem_elig  = (mem_rd_req | mem_wr_req) & ~mem_ready;
    assign grant_mem = mem_elig & (~if_elig | (last_grant == GRANT_IF));

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = (mem_rd_req | mem_wr_req) & ~mem_ready;

    // Next-state and next-output logic for the access sequencer
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        ram_en_n     = ram_en;
        ram_we_n     = ram_we;
        ram_addr_n   = ram_addr;
        ram_wdata_n  = ram_wdata;
        if_rdata_n   = if_rdata;
        mem_rdata_n  = mem_rdata;
        if_ready_n   = 1'b0;
        mem_ready_n  = 1'b0;

        case (state)
            IDLE: begin
                if (grant_mem) begin
                    state_n      = BUSY_MEM;
                    last_grant_n = GRANT_MEM;
                    cnt_n        = CNT_INIT;
                    ram_en_n     = 1'b1;
                    ram_addr_n   = mem_addr;
                    ram_we_n     = mem_wr_req;
                    if (mem_wr_req) begin
                        ram_wdata_n = data_in;
                    end
                end else if (if_elig) begin
                    state_n      = BUSY_IF;
                    last_grant_n = GRANT_IF;
                    cnt_n        = CNT_INIT;
                    ram_en_n     = 1'b1;
                    ram_addr_n   = if_addr;
                    ram_we_n     = 1'b0;
                end
            end

            BUSY_IF, BUSY_MEM: begin
                if (cnt == 4'd0) begin
                    state_n  = IDLE;
                    ram_en_n = 1'b0;
                    ram_we_n = 1'b0;
                    if (state == BUSY_IF) begin
                        if_rdata_n = ram_rdata;
                        if_ready_n = 1'b1;
                    end else begin
                        if (!ram_we) begin
                            mem_rdata_n = ram_rdata;
                        end
                        mem_ready_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end

            default: begin
                state_n  = IDLE;
                ram_en_n = 1'b0;
                ram_we_n = 1'b0;
            end
        endcase
    end

    // State and registered outputs; a synchronous reset abandons any access
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= GRANT_IF;
            cnt        <= 4'd0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
            ram_en     <= ram_en_n;
            ram_we     <= ram_we_n;
            ram_addr   <= ram_addr_n;
            ram_wdata  <= ram_wdata_n;
            if_rdata   <= if_rdata_n;
            mem_rdata  <= mem_rdata_n;
            if_ready   <= if_ready_n;
            mem_ready  <= mem_ready_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed vector table, hand-written corner sequences and a randomized run,
// all checked against a transaction-timeline reference model.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, mem_rd_req, mem_wr_req;
    logic [31:0] if_addr, mem_addr, data_in, ram_rdata;
    logic        ram_en, ram_we, if_ready, mem_ready, stall_if, stall_mem;
    logic [31:0] ram_addr, ram_wdata, if_rdata, mem_rdata;

    typedef struct packed {
        logic        rst;
        logic        ifq;
        logic        rd;
        logic        wr;
        logic [31:0] if_addr;
        logic [31:0] mem_addr;
        logic [31:0] data_in;
        logic [31:0] rdata;
        logic        chk;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        cad;
        logic        e_ifr;
        logic        e_memr;
        logic        e_sif;
        logic        e_smem;
        logic [31:0] e_ifd;
        logic [31:0] e_memd;
    } vector_t;

    vector_t vecs [16];

    int checks = 0;
    int errors = 0;

    // Reference model: an access is a window of cycles on a timeline
    int          cyc;
    int          acc_side;      // 0 none, 1 IF, 2 MEM
    int          acc_start;     // first cycle with ram_en high
    int          last_side;
    int          ready_side;
    int          ready_cyc;
    bit          acc_write;
    bit          m_valid;
    logic [31:0] acc_addr, acc_wdata, m_if_rdata, m_mem_rdata;
    logic        e_en, e_we, e_ifr, e_memr, e_sif, e_smem;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LATENCY(LATENCY)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .mem_rd_req(mem_rd_req),
        .mem_wr_req(mem_wr_req),
        .mem_addr  (mem_addr),
        .data_in   (data_in),
        .ram_rdata (ram_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    // Free-running clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ifq, input logic rd, input logic wr,
                                 input logic [31:0] ia, input logic [31:0] ma,
                                 input logic [31:0] di, input logic [31:0] rdt);
        reset      = rst;
        if_req     = ifq;
        mem_rd_req = rd;
        mem_wr_req = wr;
        if_addr    = ia;
        mem_addr   = ma;
        data_in    = di;
        ram_rdata  = rdt;
    endtask

    task automatic modelExpect();
        int acc_end;
        acc_end = acc_start + LATENCY - 1;
        e_en   = (acc_side != 0) && (cyc >= acc_start) && (cyc <= acc_end);
        e_we   = e_en && acc_write;
        e_ifr  = (ready_side == 1) && (cyc == ready_cyc);
        e_memr = (ready_side == 2) && (cyc == ready_cyc);
        e_sif  = if_req && !e_ifr;
        e_smem = (mem_rd_req || mem_wr_req) && !e_memr;
    endtask

    task automatic modelAdvance();
        int acc_end;
        int winner;
        bit if_elig, mem_elig;
        acc_end = acc_start + LATENCY - 1;
        if (!reset) begin
            acc_side    = 0;
            acc_start   = 0;
            last_side   = 1;
            ready_side  = 0;
            ready_cyc   = -1;
            m_if_rdata  = 32'h0;
            m_mem_rdata = 32'h0;
            m_valid     = 1'b1;
        end else if (m_valid) begin
            if (e_en && cyc == acc_end) begin
                if (acc_side == 1) m_if_rdata = ram_rdata;
                else if (!acc_write) m_mem_rdata = ram_rdata;
                ready_side = acc_side;
                ready_cyc  = cyc + 1;
            end else if (acc_side == 0 || cyc > acc_end) begin
                if_elig  = if_req && !e_ifr;
                mem_elig = (mem_rd_req || mem_wr_req) && !e_memr;
                winner   = 0;
                if (if_elig && mem_elig) winner = (last_side == 2) ? 1 : 2;
                else if (mem_elig) winner = 2;
                else if (if_elig) winner = 1;
                if (winner != 0) begin
                    acc_side  = winner;
                    acc_start = cyc + 1;
                    last_side = winner;
                    acc_write = (winner == 2) && mem_wr_req;
                    acc_addr  = (winner == 2) ? mem_addr : if_addr;
                    if (acc_write) acc_wdata = data_in;
                end
            end
        end
        cyc++;
    endtask

    task automatic compareModel();
        checkOutput("model_ram_en", {31'b0, ram_en}, {31'b0, e_en});
        checkOutput("model_ram_we", {31'b0, ram_we}, {31'b0, e_we});
        checkOutput("model_if_ready", {31'b0, if_ready}, {31'b0, e_ifr});
        checkOutput("model_mem_ready", {31'b0, mem_ready}, {31'b0, e_memr});
        checkOutput("model_stall_if", {31'b0, stall_if}, {31'b0, e_sif});
        checkOutput("model_stall_mem", {31'b0, stall_mem}, {31'b0, e_smem});
        checkOutput("model_if_rdata", if_rdata, m_if_rdata);
        checkOutput("model_mem_rdata", mem_rdata, m_mem_rdata);
        if (e_en) checkOutput("model_ram_addr", ram_addr, acc_addr);
        if (e_we) checkOutput("model_ram_wdata", ram_wdata, acc_wdata);
    endtask

    task automatic startCycle(input logic rst, input logic ifq, input logic rd, input logic wr,
                              input logic [31:0] ia, input logic [31:0] ma,
                              input logic [31:0] di, input logic [31:0] rdt);
        applyStimulus(rst, ifq, rd, wr, ia, ma, di, rdt);
        @(negedge clock);
        modelExpect();
        if (m_valid) compareModel();
    endtask

    task automatic endCycle();
        modelAdvance();
        @(posedge clock);
        #1;
    endtask

    task automatic resetDut(input int n);
        for (int k = 0; k < n; k++) begin
            startCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
            endCycle();
        end
    endtask

    // Main test sequence
    initial begin
        vector_t     v;
        logic [31:0] gq [$];
        logic [31:0] exp_g [4];
        logic        prev_en;
        int          we_cnt, rdy_cnt;
        logic        rst;
        bit          if_hold, mem_hold, prev_ifr, prev_memr;
        logic        r_rd, r_wr;
        logic [31:0] ia, ma, di;
        int          kind;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        m_valid = 1'b0; cyc = 0; acc_side = 0; acc_start = 0; last_side = 1;
        ready_side = 0; ready_cyc = -1; acc_write = 1'b0;
        acc_addr = 32'h0; acc_wdata = 32'h0; m_if_rdata = 32'h0; m_mem_rdata = 32'h0;

        // rst ifq rd wr | if_addr mem_addr data_in rdata | chk en we addr wdata cad | ifr memr sif smem | if_rdata mem_rdata
        vecs[0]  = '{1'b0,1'b1,1'b1,1'b0, 32'h40,32'h8,32'h0,32'h0, 1'b0,1'b0,1'b0,32'h0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b0, 32'h40,32'h8,32'h0,32'h0, 1'b1,1'b0,1'b0,32'h0,32'h0,1'b1, 1'b0,1'b0,1'b1,1'b1, 32'h0,32'h0};
        vecs[2]  = '{1'b1,1'b1,1'b1,1'b0, 32'h40,32'h8,32'h0,32'h0, 1'b1,1'b0,1'b0,32'h0,32'h0,1'b1, 1'b0,1'b0,1'b1,1'b1, 32'h0,32'h0};
        vecs[3]  = '{1'b1,1'b0,1'b1,1'b0, 32'h40,32'h8,32'h0,32'h0, 1'b1,1'b1,1'b0,32'h8,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0};
        vecs[4]  = '{1'b1,1'b0,1'b1,1'b0, 32'h40,32'h8,32'h0,32'hCAFE0001, 1'b1,1'b1,1'b0,32'h8,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0};
        vecs[5]  = '{1'b1,1'b0,1'b1,1'b0, 32'h40,32'h8,32'h0,32'h0, 1'b1,1'b0,1'b0,32'h0,32'h0,1'b0, 1'b0,1'b1,1'b0,1'b0, 32'h0,32'hCAFE0001};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0, 32'h40,32'h8,32'h0,32'h0, 1'b1,1'b0,1'b0,32'h0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'hCAFE0001};
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b0, 32'h40,32'h8,32'h0,32'h0, 1'b1,1'b0,1'b0,32'h0,32'h0,1'b0, 1'b0,1'b0,1'b1,1'b0, 32'h0,32'hCAFE0001};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0, 32'h40,32'h8,32'h0,32'h0, 1'b1,1'b1,1'b0,32'h40,32'h0,1'b0, 1'b0,1'b0,1'b1,1'b0, 32'h0,32'hCAFE0001};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b0, 32'h40,32'h8,32'h0,32'h1234ABCD, 1'b1,1'b1,1'b0,32'h40,32'h0,1'b0, 1'b0,1'b0,1'b1,1'b0, 32'h0,32'hCAFE0001};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b0, 32'h40,32'h8,32'h0,32'h0, 1'b1,1'b0,1'b0,32'h0,32'h0,1'b0, 1'b1,1'b0,1'b0,1'b0, 32'h1234ABCD,32'hCAFE0001};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b1, 32'h40,32'h100,32'hDEADBEEF,32'h0, 1'b1,1'b0,1'b0,32'h0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b1, 32'h1234ABCD,32'hCAFE0001};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b1, 32'h40,32'h200,32'h11111111,32'h55555555, 1'b1,1'b1,1'b1,32'h100,32'hDEADBEEF,1'b0, 1'b0,1'b0,1'b0,1'b1, 32'h1234ABCD,32'hCAFE0001};
        vecs[13] = '{1'b1,1'b0,1'b0,1'b1, 32'h40,32'h200,32'h11111111,32'h77777777, 1'b1,1'b1,1'b1,32'h100,32'hDEADBEEF,1'b0, 1'b0,1'b0,1'b0,1'b1, 32'h1234ABCD,32'hCAFE0001};
        vecs[14] = '{1'b1,1'b0,1'b0,1'b1, 32'h40,32'h200,32'h11111111,32'h0, 1'b1,1'b0,1'b0,32'h0,32'h0,1'b0, 1'b0,1'b1,1'b0,1'b0, 32'h1234ABCD,32'hCAFE0001};
        vecs[15] = '{1'b1,1'b0,1'b0,1'b0, 32'h40,32'h200,32'h11111111,32'h0, 1'b1,1'b0,1'b0,32'h0,32'h0,1'b0, 1'b0,1'b0,1'b0,1'b0, 32'h1234ABCD,32'hCAFE0001};

        @(posedge clock);
        #1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 16; i++) begin
            v = vecs[i];
            startCycle(v.rst, v.ifq, v.rd, v.wr, v.if_addr, v.mem_addr, v.data_in, v.rdata);
            if (v.chk) begin
                checkOutput($sformatf("vec%0d_ram_en", i), {31'b0, ram_en}, {31'b0, v.e_en});
                checkOutput($sformatf("vec%0d_ram_we", i), {31'b0, ram_we}, {31'b0, v.e_we});
                checkOutput($sformatf("vec%0d_if_ready", i), {31'b0, if_ready}, {31'b0, v.e_ifr});
                checkOutput($sformatf("vec%0d_mem_ready", i), {31'b0, mem_ready}, {31'b0, v.e_memr});
                checkOutput($sformatf("vec%0d_stall_if", i), {31'b0, stall_if}, {31'b0, v.e_sif});
                checkOutput($sformatf("vec%0d_stall_mem", i), {31'b0, stall_mem}, {31'b0, v.e_smem});
                checkOutput($sformatf("vec%0d_if_rdata", i), if_rdata, v.e_ifd);
                checkOutput($sformatf("vec%0d_mem_rdata", i), mem_rdata, v.e_memd);
                if (v.e_en || v.cad) checkOutput($sformatf("vec%0d_ram_addr", i), ram_addr, v.e_addr);
                if (v.e_we || v.cad) checkOutput($sformatf("vec%0d_ram_wdata", i), ram_wdata, v.e_wdata);
            end
            endCycle();
        end

        $display("[TB] contention sequence");
        resetDut(2);
        exp_g[0] = 32'hB0; exp_g[1] = 32'hA0; exp_g[2] = 32'hB0; exp_g[3] = 32'hA0;
        prev_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            startCycle(1'b1, 1'b1, 1'b1, 1'b0, 32'hA0, 32'hB0, 32'h0, $urandom);
            if (ram_en && !prev_en) gq.push_back(ram_addr);
            prev_en = ram_en;
            checkOutput("ready_overlap", {31'b0, if_ready & mem_ready}, 32'h0);
            endCycle();
        end
        checkOutput("grant_count", gq.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < gq.size()) checkOutput($sformatf("grant%0d_addr", k), gq[k], exp_g[k]);
        end

        $display("[TB] reset during access");
        resetDut(2);
        startCycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC0, 32'h0, 32'h0);          endCycle();
        startCycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC0, 32'h0, 32'h0);          endCycle();
        startCycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC0, 32'h0, 32'hDDDD0001);   endCycle();
        startCycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC0, 32'h0, 32'h0);
        checkOutput("load_mem_rdata", mem_rdata, 32'hDDDD0001);
        endCycle();
        startCycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC4, 32'h0, 32'h0);          endCycle();
        startCycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC4, 32'h0, 32'hEEEE0002);
        checkOutput("mid_ram_en", {31'b0, ram_en}, 32'h1);
        endCycle();
        startCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hC4, 32'h0, 32'hEEEE0002);
        checkOutput("rst_ram_en", {31'b0, ram_en}, 32'h0);
        checkOutput("rst_mem_ready", {31'b0, mem_ready}, 32'h0);
        checkOutput("rst_mem_rdata", mem_rdata, 32'h0);
        endCycle();
        for (int k = 0; k < 2; k++) begin
            startCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'hEEEE0002);
            checkOutput("rst_no_late_ready", {31'b0, mem_ready}, 32'h0);
            endCycle();
        end

        $display("[TB] read and write together");
        we_cnt  = 0;
        rdy_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) startCycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h8, 32'hA5A5A5A5, $urandom);
            else       startCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8, 32'hA5A5A5A5, $urandom);
            if (ram_we) begin
                we_cnt++;
                checkOutput("rdwr_ram_addr", ram_addr, 32'h8);
                checkOutput("rdwr_ram_wdata", ram_wdata, 32'hA5A5A5A5);
            end
            if (mem_ready) rdy_cnt++;
            endCycle();
        end
        checkOutput("rdwr_we_cycles", we_cnt, 32'd2);
        checkOutput("rdwr_ready_count", rdy_cnt, 32'd1);
        checkOutput("rdwr_mem_rdata", mem_rdata, 32'h0);

        $display("[TB] randomized traffic");
        resetDut(2);
        if_hold = 1'b0; mem_hold = 1'b0; prev_ifr = 1'b0; prev_memr = 1'b0;
        r_rd = 1'b0; r_wr = 1'b0; ia = 32'h0; ma = 32'h0; di = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 149) != 0);
            if (if_hold && (prev_ifr || $urandom_range(0, 31) == 0)) begin
                if_hold = 1'b0;
            end else if (!if_hold && $urandom_range(0, 2) == 0) begin
                if_hold = 1'b1;
                ia = $urandom;
            end
            if (mem_hold && (prev_memr || $urandom_range(0, 31) == 0)) begin
                mem_hold = 1'b0;
            end else if (!mem_hold && $urandom_range(0, 2) == 0) begin
                mem_hold = 1'b1;
                kind = $urandom_range(0, 2);
                r_rd = (kind != 1);
                r_wr = (kind != 0);
                ma = $urandom;
                di = $urandom;
            end
            startCycle(rst, if_hold, mem_hold && r_rd, mem_hold && r_wr, ia, ma, di, $urandom);
            prev_ifr  = e_ifr;
            prev_memr = e_memr;
            endCycle();
            if (!rst) begin
                if_hold  = 1'b0;
                mem_hold = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
